// File: rtl/bcd_serial_subtractor_pkg.sv
// bcd_serial_subtractor_pkg: shared BCD constants and FSM state encodings
package bcd_serial_subtractor_pkg;
    localparam int BCD_RADIX = 10;
    localparam int BCD_MAX   = 9;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SUB  = 2'd1;
    localparam logic [1:0] S_COMP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
endpackage

// File: rtl/bcd_digit_sub.sv
// bcd_digit_sub: single BCD digit x - y - bin with ten's-complement correction
module bcd_digit_sub
    import bcd_serial_subtractor_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);
    logic [4:0] t;
    always_comb begin
        t    = {1'b0, x} - {1'b0, y} - {4'b0, bin};
        bout = t[4];
        d    = bout ? t[3:0] + 4'(BCD_RADIX) : t[3:0];
    end
endmodule

// File: rtl/bcd_serial_subtractor.sv
// bcd_serial_subtractor: digit-serial packed-BCD |a-b| with sign and invalid flags
module bcd_serial_subtractor
    import bcd_serial_subtractor_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NDIGITS-1:0] a,
    input  logic [4*NDIGITS-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NDIGITS-1:0] diff,
    output logic                 neg,
    output logic                 invalid
);
    localparam int W  = 4 * NDIGITS;
    localparam int CW = NDIGITS > 1 ? $clog2(NDIGITS) : 1;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, r_q, r_d, diff_q, diff_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          brw_q, brw_d, neg_q, neg_d, inv_q, inv_d;
    logic          bad, last, bout;
    logic [3:0]    dx, dy, dd;
    logic [W-1:0]  r_sh;

    // One borrow cell serves both passes; COMP computes 0 - r_i - borrow
    assign dx = (state_q == S_SUB) ? a_q[3:0] : 4'd0;
    assign dy = (state_q == S_SUB) ? b_q[3:0] : r_q[3:0];

    bcd_digit_sub u_digit (
        .x   (dx),
        .y   (dy),
        .bin (brw_q),
        .d   (dd),
        .bout(bout)
    );

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < NDIGITS; i++)
            if (a[4*i +: 4] > 4'(BCD_MAX) || b[4*i +: 4] > 4'(BCD_MAX)) bad = 1'b1;
    end

    assign last = (cnt_q == CW'(NDIGITS - 1));
    assign r_sh = {dd, r_q[W-1:4]};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        diff_d  = diff_q;
        neg_d   = neg_q;
        inv_d   = inv_q;
        case (state_q)
            S_IDLE: if (start) begin
                a_d     = a;
                b_d     = b;
                brw_d   = 1'b0;
                cnt_d   = '0;
                state_d = bad ? S_DONE : S_SUB;
                if (bad) begin
                    diff_d = '0;
                    neg_d  = 1'b0;
                    inv_d  = 1'b1;
                end
            end
            S_SUB: begin
                a_d   = a_q >> 4;
                b_d   = b_q >> 4;
                r_d   = r_sh;
                brw_d = bout;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    if (bout) begin
                        state_d = S_COMP;
                        cnt_d   = '0;
                        brw_d   = 1'b0;
                    end else begin
                        state_d = S_DONE;
                        diff_d  = r_sh;
                        neg_d   = 1'b0;
                        inv_d   = 1'b0;
                    end
                end
            end
            S_COMP: begin
                r_d   = r_sh;
                brw_d = bout;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    state_d = S_DONE;
                    diff_d  = r_sh;
                    neg_d   = 1'b1;
                    inv_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            diff_q  <= '0;
            neg_q   <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            diff_q  <= diff_d;
            neg_q   <= neg_d;
            inv_q   <= inv_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign diff    = diff_q;
    assign neg     = neg_q;
    assign invalid = inv_q;
endmodule
